// File: rtl/alu_pkg.sv
// Purpose : shared encodings for the ALU execute stage (ALUOPR funct3 codes, FSM states).
// Latency : n/a (constants only).
// Backpressure : n/a.
package alu_pkg;

    // ALUOPR encodings (RV32I funct3)
    localparam logic [2:0] ALU_ADD  = 3'b000;  // ADD, or SUB when SUBORSRA=1
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;  // SRL, or SRA when SUBORSRA=1
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    // Execute-stage FSM states
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

endpackage

// File: rtl/alu_serial_shifter.sv
// Purpose : iterative 1-bit/cycle shifter; owns the shift register and remaining-count.
// Latency : shamt cycles after start; done/result are combinational during the last step.
// Backpressure : none; the caller must only pulse start when it can take the result.
// Ports: clk, rst (async active-high), start, dir (0=left,1=right), arith (sign-fill on right),
//        data, shamt -> busy (shift in progress), done (final step this cycle), result (value after this step).
module alu_serial_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dir,
    input  logic            arith,
    input  logic [XLEN-1:0] data,
    input  logic [SHW-1:0]  shamt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] sh_reg;
    logic [SHW-1:0]  cnt;
    logic            dir_r;
    logic            arith_r;
    logic [XLEN-1:0] step;

    // One-bit shift of the held value; right shifts fill with the sign bit only for SRA.
    always_comb begin
        step = sh_reg;
        if (dir_r) begin
            step = {arith_r & sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
        end else begin
            step = {sh_reg[XLEN-2:0], 1'b0};
        end
    end

    // The last step's output is handed over directly so the caller can
    // register it on the same edge the count reaches zero.
    assign done   = busy && (cnt == SHW'(1));
    assign result = step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_reg  <= '0;
            cnt     <= '0;
            dir_r   <= 1'b0;
            arith_r <= 1'b0;
            busy    <= 1'b0;
        end else if (start) begin
            sh_reg  <= data;
            cnt     <= shamt;
            dir_r   <= dir;
            arith_r <= arith;
            busy    <= (shamt != '0);
        end else if (busy) begin
            sh_reg <= step;
            cnt    <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Purpose : RV32I execute stage; registers result + ZERO flag, valid/ready on both sides.
// Latency : 1 cycle for non-shifts and zero-amount shifts; shamt+1 for iterative shifts
//           (1 for everything when ALU_BARREL_SHIFT_EN is defined).
// Backpressure : IN_READY drops while a shift iterates or an undrained result blocks the output.
// Ports: CLK, RESET (async active-high), IN_VALID/IN_READY, ALUOPR, SUBORSRA, OPA, OPB,
//        OUT_VALID/OUT_READY, RESULT, ZERO.
// Build option: ALU_BARREL_SHIFT_EN selects a combinational barrel shifter instead of alu_serial_shifter.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [2:0]      ALUOPR,
    input  logic            SUBORSRA,
    input  logic [XLEN-1:0] OPA,
    input  logic [XLEN-1:0] OPB,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] RESULT,
    output logic            ZERO
);

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            out_free;

    assign shamt    = OPB[SHW-1:0];
    assign out_free = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;
    assign ZERO     = (RESULT == '0);

    // Single-cycle result. In the iterative build the shift cases only matter
    // for shamt==0, where the result is OPA unchanged.
    always_comb begin
        alu_res = '0;
        case (ALUOPR)
            ALU_ADD:  alu_res = SUBORSRA ? (OPA - OPB) : (OPA + OPB);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(OPA) < $signed(OPB))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (OPA < OPB)};
            ALU_XOR:  alu_res = OPA ^ OPB;
            ALU_OR:   alu_res = OPA | OPB;
            ALU_AND:  alu_res = OPA & OPB;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  alu_res = OPA << shamt;
            ALU_SRL:  alu_res = SUBORSRA ? XLEN'($signed(OPA) >>> shamt) : (OPA >> shamt);
`else
            ALU_SLL:  alu_res = OPA;
            ALU_SRL:  alu_res = OPA;
`endif
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN

    // Every op completes in one cycle, so readiness is purely output occupancy.
    assign IN_READY = !RESET && out_free;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
        end else if (accept) begin
            RESULT    <= alu_res;
            OUT_VALID <= 1'b1;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`else

    logic [0:0]      state;
    logic            is_shift;
    logic            sh_start;
    logic            sh_busy;
    logic            sh_done;
    logic [XLEN-1:0] sh_result;

    assign is_shift = (ALUOPR == ALU_SLL) || (ALUOPR == ALU_SRL);
    assign sh_start = accept && is_shift && (shamt != '0);
    assign IN_READY = !RESET && (state == S_IDLE) && out_free;

    alu_serial_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk    (CLK),
        .rst    (RESET),
        .start  (sh_start),
        .dir    (ALUOPR == ALU_SRL),
        .arith  (SUBORSRA && (ALUOPR == ALU_SRL)),
        .data   (OPA),
        .shamt  (shamt),
        .busy   (sh_busy),
        .done   (sh_done),
        .result (sh_result)
    );

    // A shift only starts when the output is free (empty or draining this
    // edge), and nothing else loads the output while it runs, so the shift
    // result never overwrites an undrained value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
        end else begin
            if (accept && !sh_start) begin
                RESULT    <= alu_res;
                OUT_VALID <= 1'b1;
            end else if ((state == S_SHIFT) && sh_done) begin
                RESULT    <= sh_result;
                OUT_VALID <= 1'b1;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (sh_start) begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Leaving on !sh_busy keeps the FSM from sticking if the
                    // shifter ever idles without signalling done.
                    if (sh_done || !sh_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Purpose : self-checking bench for alu_exec_stage; driver pushes expected results into a
//           scoreboard queue, a negedge monitor pops/compares result, ZERO and latency.
// Latency : expected latency depends on ALU_BARREL_SHIFT_EN (all 1 when defined).
module tb_alu_exec_stage;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  aluopr;
    logic        suborsra;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    alu_exec_stage #(.XLEN(32), .SHW(5)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .ALUOPR    (aluopr),
        .SUBORSRA  (suborsra),
        .OPA       (opa),
        .OPB       (opb),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .RESULT    (result),
        .ZERO      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   head_seen = 0;
    int   last_pop  = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) begin
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic int shift_lat(input int sh);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (sh == 0) ? 1 : sh + 1;
`endif
    endfunction

    // Monitor: checks every cycle the output is presented (so a held result
    // under backpressure is re-checked), latency on first presentation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                if (!head_seen) begin
                    head_seen = 1;
                    chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                end
                chk("result", result, sb[0].res);
                chk("zero", {31'd0, zero}, {31'd0, (sb[0].res == 32'd0)});
                if (out_ready) begin
                    void'(sb.pop_front());
                    head_seen = 0;
                    last_pop  = cyc + 1;
                end
            end
        end
    end

    task automatic scramble_inputs();
        opa      = $urandom;
        opb      = $urandom;
        aluopr   = 3'($urandom_range(0, 7));
        suborsra = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [2:0] op, input logic sub, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; aluopr = op; suborsra = sub; opa = a; opb = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back('{exp_res, exp_lat, cyc + 1});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Changing inputs after accept must not disturb the in-flight op.
        scramble_inputs();
    endtask

    task automatic wait_empty();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int acc_cyc;
        bit ok;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluopr = 3'd0; suborsra = 1'b0; opa = 32'd0; opb = 32'd0;

        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD/SUB
        issue(OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
        issue(OP_ADD, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1);
        issue(OP_ADD, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
        // SLT/SLTU
        issue(OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
        issue(OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        issue(OP_SLT,  1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1);
        issue(OP_SLTU, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1);
        // Logic ops (SUBORSRA must be ignored)
        issue(OP_XOR, 1'b1, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1);
        issue(OP_OR,  1'b1, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1);
        issue(OP_AND, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
        wait_empty();

        // Shifts
        issue(OP_SRL, 1'b1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, shift_lat(31));
        issue(OP_SRL, 1'b0, 32'h8000_0000, 32'd31, 32'h0000_0001, shift_lat(31));
        issue(OP_SLL, 1'b0, 32'h0000_0001, 32'd0,  32'h0000_0001, shift_lat(0));
        issue(OP_SLL, 1'b1, 32'h0000_0001, 32'd4,  32'h0000_0010, shift_lat(4));
        issue(OP_SRL, 1'b1, 32'hF000_0000, 32'h0000_0023, 32'hFE00_0000, shift_lat(3));
        issue(OP_SRL, 1'b0, 32'hF000_0000, 32'h0000_0023, 32'h1E00_0000, shift_lat(3));
        wait_empty();

        // A shift in progress holds off new input
        issue(OP_SRL, 1'b0, 32'h0000_FF00, 32'd8, 32'h0000_00FF, shift_lat(8));
`ifndef ALU_BARREL_SHIFT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("shift_in_ready", {31'd0, in_ready}, 32'd0);
        end
`endif
        wait_empty();

        // Backpressure: result held, IN_READY low, then accept+drain on one edge
        out_ready = 1'b0;
        issue(OP_ADD, 1'b0, 32'd10, 32'd20, 32'd30, 1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("bp_valid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; aluopr = OP_XOR; suborsra = 1'b0; opa = 32'd3; opb = 32'd5;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        acc_cyc = cyc + 1;
        if (in_ready) sb.push_back('{32'd6, 1, acc_cyc});
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        chk("bp_same_edge", 32'(last_pop), 32'(acc_cyc));
        wait_empty();

        // Reset mid-run (mid-shift in the iterative build)
        issue(OP_ADD, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        wait_empty();
        issue(OP_SRL, 1'b1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, shift_lat(31));
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_zero", {31'd0, zero}, 32'd1);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        head_seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        // Any output from the discarded shift is flagged by the monitor.
        repeat (40) @(negedge clk);
        issue(OP_ADD, 1'b0, 32'd1, 32'd2, 32'd3, 1);
        wait_empty();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
